// File: rtl/ad7276_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ad7276_pkg: shared widths and packed-beat layout for the axis_ad7276 IP    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
package ad7276_pkg;

  localparam int AD7276_SAMPLE_W = 12;
  localparam int AXIS_DATA_W     = 32;
  localparam int AD7276_PAD_W    = 4;

  // Beat layout: {pad, ch1, pad, ch0}, each sample right-justified in a halfword.
  function automatic logic [AXIS_DATA_W-1:0] ad7276_pack(
    input logic [AD7276_SAMPLE_W-1:0] s0,
    input logic [AD7276_SAMPLE_W-1:0] s1
  );
    return {{AD7276_PAD_W{1'b0}}, s1, {AD7276_PAD_W{1'b0}}, s0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad7276_axis_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ad7276_axis_fifo: synchronous first-word-fall-through FIFO                 |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module ad7276_axis_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_FULL);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad7276_axis_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ad7276_axis_packer: packs AD7276 sample pairs into framed AXI4-Stream beats|
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module ad7276_axis_packer
  import ad7276_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                          fpga_clk_i,
  input  logic                          reset_i,
  input  logic                          en_0_i,
  input  logic                          en_1_i,
  input  logic                          data_rdy_i,
  input  logic [AD7276_SAMPLE_W-1:0]    data_0_i,
  input  logic [AD7276_SAMPLE_W-1:0]    data_1_i,
  output logic [AXIS_DATA_W-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic                          ovf_clr_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level_o
);

  localparam int          c_ENTRY_W   = AXIS_DATA_W + 1;
  localparam logic [15:0] c_LAST_BEAT = 16'(FRAME_LEN - 1);

  logic                   r_rdy_d;
  logic [15:0]            r_beat_cnt;
  logic                   r_overflow;
  logic                   w_capture;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_drop;
  logic                   w_last;
  logic [AD7276_SAMPLE_W-1:0] w_s0;
  logic [AD7276_SAMPLE_W-1:0] w_s1;
  logic [c_ENTRY_W-1:0]   w_din;
  logic [c_ENTRY_W-1:0]   w_dout;
  logic                   w_full;
  logic                   w_empty;

  // Rising edge of the ready level gives one event per conversion.
  assign w_capture = data_rdy_i & ~r_rdy_d & (en_0_i | en_1_i);
  assign w_pop     = m_axis_tvalid & m_axis_tready;
  assign w_accept  = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & ~w_accept;
  assign w_last    = (r_beat_cnt == c_LAST_BEAT);

  assign w_s0  = en_0_i ? data_0_i : '0;
  assign w_s1  = en_1_i ? data_1_i : '0;
  assign w_din = {w_last, ad7276_pack(w_s0, w_s1)};

  ad7276_axis_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk   (fpga_clk_i),
    .rst   (reset_i),
    .push  (w_capture),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (fill_level_o)
  );

  // Stale RAM contents are hidden while the FIFO is empty.
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_empty ? '0   : w_dout[AXIS_DATA_W-1:0];
  assign m_axis_tlast  = w_empty ? 1'b0 : w_dout[AXIS_DATA_W];
  assign overflow_o    = r_overflow;

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      r_rdy_d    <= 1'b0;
      r_beat_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rdy_d <= data_rdy_i;
      if (w_accept) begin
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad7276_axis_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ad7276_axis_packer: directed and random checks against a queue model    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_ad7276_axis_packer;

  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en0, en1, rdy, tready, clr;
  logic [11:0]   d0, d1;
  logic [31:0]   tdata;
  logic          tvalid, tlast, ovf;
  logic [FW-1:0] fill;

  always #5 clk = ~clk;

  ad7276_axis_packer #(
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FLEN)
  ) dut (
    .fpga_clk_i    (clk),
    .reset_i       (rst),
    .en_0_i        (en0),
    .en_1_i        (en1),
    .data_rdy_i    (rdy),
    .data_0_i      (d0),
    .data_1_i      (d1),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .ovf_clr_i     (clr),
    .overflow_o    (ovf),
    .fill_level_o  (fill)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of expected {tlast, tdata}, frame position, sticky flag.
  logic [32:0] q[$];
  int          fpos;
  bit          movf;
  bit          mprev;
  int          pops;
  int          last_mask;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          pop, ev;
    logic [32:0] w;
    pop = (q.size() > 0) && tready;
    ev  = rdy && !mprev && (en0 || en1);
    if (tvalid && tready) begin
      pops++;
      if (tlast) last_mask |= (1 << pops);
    end
    mprev = rdy;
    if (rst) begin
      q.delete();
      fpos  = 0;
      movf  = 0;
      mprev = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (ev && q.size() < DEPTH) begin
        w = {(fpos == FLEN - 1), 4'h0, (en1 ? d1 : 12'h000), 4'h0, (en0 ? d0 : 12'h000)};
        q.push_back(w);
        fpos = (fpos + 1) % FLEN;
        if (clr) movf = 0;
      end else if (ev) begin
        movf = 1;
      end else if (clr) begin
        movf = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("tvalid", 33'(tvalid), 33'(q.size() > 0));
    chk("fill_level", 33'(fill), 33'(q.size()));
    chk("overflow", 33'(ovf), 33'(movf));
    if (q.size() > 0) chk("head", {tlast, tdata}, q[0]);
    else              chk("idle_out", {tlast, tdata}, 33'h0);
  endtask

  task automatic strobe(input int width, input int gap);
    rdy = 1'b1;
    repeat (width) cycle();
    rdy = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en0 = 0; en1 = 0; rdy = 0; tready = 0; clr = 0; d0 = '0; d1 = '0;
    pops = 0; last_mask = 0; fpos = 0; movf = 0; mprev = 0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_state", {tvalid, tlast, ovf, tdata}, 35'h0);
    chk("reset_fill", 33'(fill), 33'h0);

    // Single capture with a 3-cycle strobe
    en0 = 1; en1 = 1; d0 = 12'hABC; d1 = 12'h123; tready = 1;
    rdy = 1;
    cycle();
    chk("t1_tvalid", 33'(tvalid), 33'h1);
    chk("t1_tdata", 33'(tdata), 33'h0123_0ABC);
    cycle();
    chk("t1_one_beat", 33'(tvalid), 33'h0);
    cycle();
    rdy = 0;
    repeat (2) cycle();

    // Channel gating
    en1 = 0; d1 = 12'hFFF; d0 = 12'h555; tready = 0;
    strobe(1, 1);
    chk("t2_gated", 33'(tdata), 33'h0000_0555);
    tready = 1;
    repeat (2) cycle();
    en0 = 0; en1 = 0;
    strobe(2, 2);
    chk("t2_no_beat", 33'(fill), 33'h0);

    // Framing from a fresh counter
    do_reset();
    en0 = 1; en1 = 1; tready = 1; pops = 0; last_mask = 0;
    for (int i = 0; i < 10; i++) begin
      d0 = 12'(i); d1 = 12'(100 + i);
      strobe(1, 1);
    end
    repeat (3) cycle();
    chk("t3_tlast_beats", 33'(last_mask), 33'((1 << 4) | (1 << 8)));
    do_reset();
    tready = 0;
    strobe(1, 1);
    chk("t3_restart_tlast", 33'(tlast), 33'h0);
    tready = 1;
    repeat (2) cycle();

    // Backpressure and overflow
    tready = 0;
    for (int i = 0; i < 6; i++) begin
      d0 = 12'(16 * i + 1); d1 = 12'(16 * i + 2);
      strobe(1, 1);
    end
    chk("t4_fill", 33'(fill), 33'(DEPTH));
    chk("t4_ovf", 33'(ovf), 33'h1);
    chk("t4_head", 33'(tdata), 33'h0002_0001);
    tready = 1;
    repeat (6) cycle();
    clr = 1; cycle(); clr = 0;
    chk("t4_ovf_clr", 33'(ovf), 33'h0);

    // Full FIFO with a write in the same cycle as a pop
    tready = 0;
    repeat (DEPTH) strobe(1, 1);
    tready = 1; d0 = 12'h7A7; d1 = 12'h5B5;
    rdy = 1;
    cycle();
    tready = 0;
    rdy = 0;
    cycle();
    chk("t5_ovf", 33'(ovf), 33'h0);
    chk("t5_fill", 33'(fill), 33'(DEPTH));
    tready = 1;
    repeat (6) cycle();

    // Reset mid-stream
    tready = 0;
    repeat (3) strobe(1, 1);
    do_reset();
    chk("t6_cleared", {tvalid, ovf, 31'(fill)}, 33'h0);
    d0 = 12'h321; d1 = 12'h654;
    strobe(1, 0);
    chk("t6_beat", {tlast, tdata}, 33'h0_0654_0321);
    tready = 1;
    repeat (2) cycle();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      en0    = 1'($urandom_range(0, 3) != 0);
      en1    = 1'($urandom_range(0, 3) != 0);
      d0     = 12'($urandom);
      d1     = 12'($urandom);
      tready = 1'($urandom_range(0, 2) == 0);
      clr    = 1'($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) rdy = ~rdy;
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ad7276_axis_packer.md
Name: ad7276_axis_packer

Overview:
- Downstream stage of the AD7276 dual-channel serial interface in the axis_ad7276 IP.
- Captures each completed conversion pair (two 12-bit samples, qualified by a data-ready strobe) and packs it into one 32-bit AXI4-Stream beat.
- Buffers beats in a small FIFO, marks frame boundaries with tlast, and reports overflow when the stream consumer stalls.

Parameters:
- FIFO_DEPTH, 16, number of buffered beats; power of two, minimum 2.
- FRAME_LEN, 256, beats per frame; tlast is asserted on the last beat; range 1 to 65535.

Ports:
- fpga_clk_i  in  1  system clock; single clock domain.
- reset_i  in  1  synchronous reset, active-high.
- en_0_i  in  1  channel 0 enable.
- en_1_i  in  1  channel 1 enable.
- data_rdy_i  in  1  conversion-done strobe from the ADC interface; level, one or more cycles wide.
- data_0_i  in  12  channel 0 sample, valid while data_rdy_i=1.
- data_1_i  in  12  channel 1 sample, valid while data_rdy_i=1.
- m_axis_tdata  out  32  packed beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tready  in  1  consumer ready.
- ovf_clr_i  in  1  clears the sticky overflow flag.
- overflow_o  out  1  sticky; set when a sample is dropped.
- fill_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - tvalid=0, tlast=0, tdata=0.
  - overflow_o=0, fill_level_o=0.
  - FIFO empty, beat counter=0, rdy_d=0.
- Capture:
  - rdy_d is data_rdy_i registered. A capture event occurs when data_rdy_i=1 and rdy_d=0, so there is exactly one event per strobe regardless of strobe width.
  - The event is ignored if en_0_i=0 and en_1_i=0.
- Packing:
  - tdata = {4'h0, s1, 4'h0, s0}.
  - s0 = en_0_i ? data_0_i : 12'h000; s1 = en_1_i ? data_1_i : 12'h000.
  - Enables are sampled in the capture cycle.
- Write acceptance:
  - A capture event is written when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a read handshake occurs in the same cycle.
  - Otherwise the beat is dropped and overflow_o is set on the next edge.
- Beat counter:
  - Increments only on accepted writes.
  - The stored tlast bit equals (counter==FRAME_LEN-1); the counter then wraps to 0.
  - Dropped beats do not advance the counter.
- FIFO:
  - First-word-fall-through; each entry is 33 bits {tlast, tdata}.
  - m_axis_tvalid = !empty; the outputs present the head entry.
  - Pop on tvalid&&tready. Outputs are stable while tvalid=1 and tready=0 (AXI rule).
- Latency:
  - A capture event in cycle N into an empty FIFO gives tvalid=1 in cycle N+1.
  - Throughput is one beat per cycle.
- Occupancy:
  - fill_level_o is registered and reflects count after each edge.
  - Simultaneous push and pop leaves count unchanged.
- Overflow:
  - ovf_clr_i=1 clears overflow_o next edge.
  - A drop in the same cycle as ovf_clr_i=1 wins, so overflow_o stays 1.
- Reset mid-operation: FIFO contents discarded, counter to 0, partial frame abandoned. The next accepted beat starts a new frame.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is one bit wider.

Decomposition:
- Shared package ad7276_pkg:
  - AD7276_SAMPLE_W=12, AXIS_DATA_W=32, pad width 4.
  - Function for the packed-word layout, so other axis_ad7276 blocks use the same format.
- One sub-module: ad7276_axis_fifo, a parameterised synchronous FWFT FIFO.
  - Ports: push, pop, din, dout, full, empty, count.
  - Implements the simultaneous push/pop-when-full rule.
- Edge detect, packing, frame counter and overflow logic stay in the top level.

Test Plan:
1. Single capture: en_0=en_1=1, data_0=12'hABC, data_1=12'h123, 3-cycle strobe, tready=1 -> exactly one beat, tdata=32'h0123_0ABC, tvalid high 1 cycle after the rising edge.
2. Channel gating: en_1=0, data_1=12'hFFF, data_0=12'h555 -> tdata=32'h0000_0555. Both enables 0 -> no beat and fill_level stays 0.
3. Framing: FRAME_LEN=4, 10 strobes, tready=1 -> tlast on beats 4 and 8 only. Reset, then 1 strobe -> tlast=0 (counter restarted).
4. Backpressure and overflow: FIFO_DEPTH=4, tready=0, 6 strobes -> fill_level=4, overflow_o=1, tdata/tvalid stable. Release tready -> first 4 samples delivered in order. Pulse ovf_clr_i -> overflow_o=0.
5. Full with simultaneous pop: FIFO full, tready=1, and a strobe in the same cycle -> write accepted, overflow_o stays 0, fill_level stays 4.
6. Reset mid-stream: 3 beats buffered, assert reset_i for 1 cycle -> tvalid=0, fill_level=0, overflow_o=0. The next strobe yields a single beat with correct data.
